alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Iterative unsigned multiply/divide sequencer that acts as the initiator on the ALU operand/result port. It issues one add or subtract per iteration through the shared ALU (op, AI, BI, CI, right, rotate, EI in; OUT, CO back) and does the shifts locally, producing a 2·dw-bit product or a dw-bit quotient plus remainder. It sits beside the CPU core. A top-level mux hands the ALU port to this block while `busy` is high.

## Interface
- `dw`, 16: data width; 8 for 6502 builds, 16 for 65Org16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global RDY, also wired to the ALU; when low this block freezes completely.
- `start`  in  1  request; sampled only in IDLE with `rdy`=1.
- `mode`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `opa`  in  dw  multiplicand or dividend; sampled with `start`.
- `opb`  in  dw  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high while ISSUE/CAPTURE are active.
- `done`  out  1  one-cycle pulse when results become valid.
- `dz`  out  1  divide-by-zero flag, valid with `done`, held until the next accepted `start`.
- `res_lo`  out  dw  product[dw-1:0] or quotient.
- `res_hi`  out  dw  product[2dw-1:dw] or remainder.
- `alu_op`  out  4  ALU op code.
- `alu_ai`, `alu_bi`  out  dw  ALU operands.
- `alu_ci`  out  1  ALU carry in.
- `alu_right`, `alu_rotate`  out  1  always 0.
- `alu_ei`  out  4  always 0.
- `alu_out`  in  dw  registered ALU result.
- `alu_co`  in  1  registered ALU carry out.

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE.
- Internal registers: `hi`, `lo` (dw each), `ovf` (1), `b` (dw), `cnt` (counts 0..dw-1), `mode_r`.
- IDLE: on `start`·`rdy`, latch `b`←opb and `mode_r`←mode, clear `cnt`.
  - Multiply: `hi`←0, `lo`←opa. Go to ISSUE.
  - Divide with opb≠0: `hi`←0, `lo`←opa. Go to ISSUE.
  - Divide with opb=0: `res_lo`←all ones, `res_hi`←opa, `dz`←1. Go to DONE.
  - Otherwise `dz`←0.
- ISSUE (drives ALU combinationally from registers):
  - Multiply: `alu_op`=0011 (add), AI=`hi`, BI = `lo[0]` ? `b` : 0, CI=0.
  - Divide: form the shifted remainder {ovf, R} = {hi, lo[dw-1]}. Drive `alu_op`=0111 (subtract), AI=R, BI=`b`, CI=1. CO=1 means no borrow.
  - The registers are not modified in ISSUE. The shifted remainder is recomputed identically in CAPTURE.
- CAPTURE (reads `alu_out`/`alu_co` registered at the end of ISSUE):
  - Multiply: {hi, lo} ← {alu_co, alu_out, lo[dw-1:1]}.
  - Divide: quotient bit q = alu_co | ovf. `hi` ← q ? alu_out : R. `lo` ← {lo[dw-2:0], q}.
  - Then `cnt`++. If `cnt` was dw-1: `res_lo`←`lo`', `res_hi`←`hi`' (the updated values) and go to DONE. Otherwise go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Results and `dz` hold until the next accepted `start`.
- `start` while not in IDLE is ignored. A `start` in the DONE cycle is ignored.
- Outside ISSUE: `alu_op`=0011, AI=BI=0, CI=0.
- Arithmetic is modulo 2^dw on the ALU path. The dw+1-bit remainder is handled by `ovf`; when `ovf`=1 the subtract always succeeds and its low dw bits are exact.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `dz`=0, `res_lo`=`res_hi`=0, internal registers 0, ALU outputs at their idle values.
- Reset mid-operation aborts at the next edge with the same values. The ALU's stale OUT is ignored.
- Latency with `rdy` held high:
  - `start` accepted at edge E; `busy` is high for cycles E+1 … E+2·dw.
  - `done` is high in cycle E+2·dw+1 (dw=16: 33 cycles after acceptance).
  - Divide-by-zero: `done` in cycle E+1 and `busy` never rises.
- `rdy`=0: no state, counter, result or output register changes, and the ALU drive stays constant.
  - Required because the ALU also holds OUT/CO while RDY is low.
  - Each low cycle extends latency by exactly one; results are unchanged.
- ALU contract: exactly one cycle from ISSUE drive to valid `alu_out`/`alu_co` in CAPTURE.

## Test plan
- dw=16, mul, opa=0x1234, opb=0x5678 → `done` 33 cycles after `start`; res_hi=0x0626, res_lo=0x0060, dz=0.
- mul 0xFFFF×0xFFFF → res_hi=0xFFFE, res_lo=0x0001. Back-to-back `start` in the cycle after `done` is accepted, and 0x0000×0xBEEF → 0x0000/0x0000.
- div 0xFFFF/0x0007 → res_lo=0x2492, res_hi=0x0001. div 0xFFFF/0x8001 → q=0x0001, r=0x7FFE (exercises the `ovf` path).
- div 0x1234/0x0000 → `done` one cycle after `start`, busy stays 0, res_lo=0xFFFF, res_hi=0x1234, dz=1.
- mul 0x1234×0x5678 with `rdy` low for 5 cycles during CAPTURE of iteration 7 → `done` at 38 cycles, same product, ALU drive constant while stalled.
- `reset` pulsed at cycle 10 of a divide → next cycle IDLE, busy=0, done=0, res=0. A `start` pulsed while busy is ignored with no result change.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer driving the shared ALU port.
// One add/subtract per iteration through the ALU; shifts are done locally.
module alu_muldiv_seq #(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rdy,
    input  logic          start,
    input  logic          mode,
    input  logic [dw-1:0] opa,
    input  logic [dw-1:0] opb,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [dw-1:0] res_lo,
    output logic [dw-1:0] res_hi,
    output logic [3:0]    alu_op,
    output logic [dw-1:0] alu_ai,
    output logic [dw-1:0] alu_bi,
    output logic          alu_ci,
    output logic          alu_right,
    output logic          alu_rotate,
    output logic [3:0]    alu_ei,
    input  logic [dw-1:0] alu_out,
    input  logic          alu_co
);

    localparam int CW = (dw > 1) ? $clog2(dw) : 1;
    localparam logic [CW-1:0] LAST = CW'(dw - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [dw-1:0] hi, lo, b;
    logic [dw-1:0] hi_n, lo_n, b_n;
    logic [dw-1:0] res_lo_n, res_hi_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mode_r, mode_n, dz_n;
    logic          ovf, q;
    logic [dw-1:0] rem;

    // Shifted partial remainder is dw+1 bits wide; ovf is its top bit.
    assign ovf = hi[dw-1];
    assign rem = {hi[dw-2:0], lo[dw-1]};
    assign q   = alu_co | ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
            cnt    <= '0;
            mode_r <= 1'b0;
            dz     <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
        end else if (rdy) begin
            state  <= state_n;
            hi     <= hi_n;
            lo     <= lo_n;
            b      <= b_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            dz     <= dz_n;
            res_lo <= res_lo_n;
            res_hi <= res_hi_n;
        end
    end

    always_comb begin
        state_n  = state;
        hi_n     = hi;
        lo_n     = lo;
        b_n      = b;
        cnt_n    = cnt;
        mode_n   = mode_r;
        dz_n     = dz;
        res_lo_n = res_lo;
        res_hi_n = res_hi;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    b_n    = opb;
                    mode_n = mode;
                    cnt_n  = '0;
                    dz_n   = 1'b0;
                    if (mode && (opb == '0)) begin
                        res_lo_n = '1;
                        res_hi_n = opa;
                        dz_n     = 1'b1;
                        state_n  = S_DONE;
                    end else begin
                        hi_n    = '0;
                        lo_n    = opa;
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_n = S_CAPT;
            S_CAPT: begin
                if (mode_r) begin
                    hi_n = q ? alu_out : rem;
                    lo_n = {lo[dw-2:0], q};
                end else begin
                    {hi_n, lo_n} = {alu_co, alu_out, lo[dw-1:1]};
                end
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    res_lo_n = lo_n;
                    res_hi_n = hi_n;
                    state_n  = S_DONE;
                end else begin
                    state_n = S_ISSUE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op = 4'b0011;
        alu_ai = '0;
        alu_bi = '0;
        alu_ci = 1'b0;
        if (state == S_ISSUE) begin
            if (mode_r) begin
                alu_op = 4'b0111;
                alu_ai = rem;
                alu_bi = b;
                alu_ci = 1'b1;
            end else begin
                alu_ai = hi;
                alu_bi = lo[0] ? b : '0;
            end
        end
    end

    assign alu_right  = 1'b0;
    assign alu_rotate = 1'b0;
    assign alu_ei     = 4'b0000;
    assign busy       = (state == S_ISSUE) || (state == S_CAPT);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: registered ALU stand-in, arithmetic reference
// model with a latency counter, per-cycle compare, directed + random ops.
module tb_alu_muldiv_seq;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, rdy, start, mode;
    logic [DW-1:0] opa, opb;
    logic          busy, done, dz;
    logic [DW-1:0] res_lo, res_hi;
    logic [3:0]    alu_op, alu_ei;
    logic [DW-1:0] alu_ai, alu_bi;
    logic          alu_ci, alu_right, alu_rotate;
    logic [DW-1:0] alu_out = '0;
    logic          alu_co = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq #(.dw(DW)) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .start(start), .mode(mode),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .dz(dz),
        .res_lo(res_lo), .res_hi(res_hi), .alu_op(alu_op),
        .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
        .alu_right(alu_right), .alu_rotate(alu_rotate), .alu_ei(alu_ei),
        .alu_out(alu_out), .alu_co(alu_co)
    );

    always #5 clk = ~clk;

    // ALU stand-in: one-cycle registered add / subtract, holds on RDY low.
    always @(posedge clk) begin
        if (rdy) begin
            if (alu_op == 4'b0111)
                {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, ~alu_bi} + 17'(alu_ci);
            else
                {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, alu_bi} + 17'(alu_ci);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    // Reference model: results from plain arithmetic, timing from a count
    // of rdy-qualified cycles since acceptance.
    bit            en = 0;
    bit            act = 0;
    bit            held = 0;
    int            prog = 0, total = 0;
    logic [DW-1:0] m_lo = '0, m_hi = '0, p_lo, p_hi;
    bit            m_dz = 0;
    logic [31:0]   prod;

    always @(posedge clk) begin
        held = !rdy && !reset;
        if (reset) begin
            en   = 1;
            act  = 0;
            m_lo = '0;
            m_hi = '0;
            m_dz = 0;
        end else if (rdy) begin
            if (!act) begin
                if (start) begin
                    act  = 1;
                    prog = 1;
                    m_dz = 0;
                    total = 2 * DW + 1;
                    if (!mode) begin
                        prod = 32'(opa) * 32'(opb);
                        p_lo = prod[15:0];
                        p_hi = prod[31:16];
                    end else if (opb == '0) begin
                        p_lo = '1;
                        p_hi = opa;
                        m_dz = 1;
                        total = 1;
                    end else begin
                        p_lo = opa / opb;
                        p_hi = opa % opb;
                    end
                    if (total == 1) begin
                        m_lo = p_lo;
                        m_hi = p_hi;
                    end
                end
            end else if (prog == total) begin
                act = 0;
            end else begin
                prog++;
                if (prog == total) begin
                    m_lo = p_lo;
                    m_hi = p_hi;
                end
            end
        end
    end

    logic [3:0]    s_op;
    logic [DW-1:0] s_ai, s_bi;
    logic          s_ci;

    always @(negedge clk) begin
        if (en) begin
            chk("busy", 32'(busy), 32'(act && prog < total));
            chk("done", 32'(done), 32'(act && prog == total));
            chk("dz", 32'(dz), 32'(m_dz));
            chk("res_lo", 32'(res_lo), 32'(m_lo));
            chk("res_hi", 32'(res_hi), 32'(m_hi));
            chk("alu_fixed", {alu_right, alu_rotate, alu_ei}, 32'd0);
            if (!(act && prog < total))
                chk("alu_idle", {alu_op, alu_ai, alu_bi, alu_ci}, {4'b0011, 33'd0});
            if (held)
                chk("alu_stall", {alu_op, alu_ai, alu_bi, alu_ci}, {s_op, s_ai, s_bi, s_ci});
        end
        s_op = alu_op;
        s_ai = alu_ai;
        s_bi = alu_bi;
        s_ci = alu_ci;
    end

    // One operation; optional stall, busy-time start poke, and reset pulse.
    task automatic run_op(input bit md, input logic [DW-1:0] a, input logic [DW-1:0] bb,
                          input int stall_at, input int stall_len, input int poke_at,
                          input int reset_at, output int lat);
        int n;
        @(negedge clk);
        start = 1; mode = md; opa = a; opb = bb;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        opa = $urandom;
        opb = $urandom;
        n = 1;
        lat = -1;
        while (1) begin
            if (n == reset_at + 1 && reset_at > 0) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_res", {res_hi, res_lo}, 32'd0);
                reset = 0;
                break;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (n > 300) begin
                chk("timeout", 32'(n), 32'd0);
                break;
            end
            if (n == stall_at) rdy = 0;
            if (n == stall_at + stall_len) rdy = 1;
            if (n == poke_at) begin start = 1; mode = ~md; end
            if (n == poke_at + 1) start = 0;
            if (n == reset_at) reset = 1;
            @(negedge clk);
            n++;
        end
        rdy = 1;
        start = 0;
    endtask

    int lat;

    initial begin
        reset = 1; rdy = 1; start = 0; mode = 0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, dz, res_hi, res_lo}, 35'd0);
        chk("reset_alu", {alu_op, alu_ai, alu_bi, alu_ci}, {4'b0011, 33'd0});
        reset = 0;

        run_op(0, 16'h1234, 16'h5678, -1, 0, -1, -1, lat);
        chk("mul1_lat", 32'(lat), 32'd33);
        chk("mul1_res", {res_hi, res_lo, 15'd0, dz}, {32'h06260060, 16'd0});
        run_op(0, 16'hFFFF, 16'hFFFF, -1, 0, -1, -1, lat);
        chk("mul2_res", {res_hi, res_lo}, 32'hFFFE0001);
        run_op(0, 16'h0000, 16'hBEEF, -1, 0, -1, -1, lat);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("mul3_res", {res_hi, res_lo}, 32'h00000000);
        run_op(1, 16'hFFFF, 16'h0007, -1, 0, 4, -1, lat);
        chk("div1_res", {res_hi, res_lo}, 32'h00012492);
        run_op(1, 16'hFFFF, 16'h8001, -1, 0, -1, -1, lat);
        chk("div2_res", {res_hi, res_lo}, 32'h7FFE0001);
        run_op(1, 16'h1234, 16'h0000, -1, 0, -1, -1, lat);
        chk("dz_lat", 32'(lat), 32'd1);
        chk("dz_res", {res_hi, res_lo, 15'd0, dz}, {32'h1234FFFF, 16'd1});
        run_op(0, 16'h1234, 16'h5678, 16, 5, -1, -1, lat);
        chk("stall_lat", 32'(lat), 32'd38);
        chk("stall_res", {res_hi, res_lo}, 32'h06260060);
        run_op(1, 16'hABCD, 16'h0013, -1, 0, -1, 10, lat);

        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] a, bb;
            a  = $urandom;
            bb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 5) == 0) bb = 16'hFFFF - 16'($urandom_range(0, 3));
            run_op(1'($urandom), a, bb,
                   ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 34),
                   $urandom_range(1, 4),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : -1,
                   ($urandom_range(0, 14) == 0) ? $urandom_range(2, 30) : -1, lat);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
